// File: rtl/vfm_core_link.sv
// Toggle-handshake FIFO link between two cores sharing one clock.
// Optional status port is enabled by defining LINK_STATUS_EN.
module vfm_core_link #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             Clock_pin,
    input  logic             Resetn_pin,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_req,
    output logic             tx_ack,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_req,
    input  logic             rx_ack
`ifdef LINK_STATUS_EN
    ,
    output logic [WIDTH-1:0] status
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop, load;

    // Full is judged on the registered count, so a pop in the same cycle
    // cannot make room for a waiting push until the next edge.
    assign push = (tx_req != tx_ack) && (count != CW'(DEPTH));

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every register samples pre-edge values regardless of order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise
        // paths that do not assign them would infer latches.
        next_state = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (rx_ack == rx_req) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; reset only clears
    // the pointers and count, which makes the old contents unreachable.
    always_ff @(posedge Clock_pin) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            tx_ack  <= 1'b0;
            rx_req  <= 1'b0;
            rx_data <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tx_ack <= tx_req;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (load) begin
                rx_data <= mem[rd_ptr];
                rx_req  <= ~rx_req;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LINK_STATUS_EN
    localparam int TW = WIDTH - 5;

    logic [TW-1:0] transfer_count;

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            transfer_count <= '0;
        end else if (pop) begin
            transfer_count <= transfer_count + TW'(1);
        end
    end

    assign status = {transfer_count, 5'(count)};
`endif

endmodule

// File: tb/tb_vfm_core_link.sv
// Scoreboard bench for vfm_core_link: a producer/consumer pair drives the
// toggle handshakes while a monitor checks every presented word in order.
module tb_vfm_core_link;

    localparam int WIDTH = 14;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req;
    logic             tx_ack;
    logic [WIDTH-1:0] rx_data;
    logic             rx_req;
    logic             rx_ack;
`ifdef LINK_STATUS_EN
    logic [WIDTH-1:0] status;
`endif

    int               checks;
    int               errors;
    logic [WIDTH-1:0] exp_q[$];
    bit               cons_auto;
    int               ack_budget;
    int               acks_done;
    int               max_count;
    int               exp_wr;

    vfm_core_link #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock_pin  (clk),
        .Resetn_pin (rst_n),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_ack     (tx_ack),
        .rx_data    (rx_data),
        .rx_req     (rx_req),
        .rx_ack     (rx_ack)
`ifdef LINK_STATUS_EN
        ,
        .status     (status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: every new rx_req toggle is a presented word; compare against the queue head.
    initial begin : monitor
        logic last_rx;
        last_rx   = 1'b0;
        max_count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_rx = 1'b0;
            end else begin
                if (int'(dut.count) > max_count) max_count = int'(dut.count);
                if (rx_req != last_rx) begin
                    last_rx = rx_req;
                    if (exp_q.size() == 0)
                        check("rx_queue_underrun", 32'(exp_q.size()), 32'd1);
                    else
                        check("rx_data_order", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Consumer: acts just after the falling edge so grants from the main flow are seen deterministically.
    initial begin : consumer
        rx_ack    = 1'b0;
        acks_done = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                rx_ack    = 1'b0;
                acks_done = 0;
            end else if (rx_req != rx_ack && (cons_auto || acks_done < ack_budget)) begin
                rx_ack = rx_req;
                if (!cons_auto) acks_done++;
            end
        end
    end

    task automatic start_push(input logic [WIDTH-1:0] word);
        tx_data = word;
        tx_req  = !tx_req;
        exp_q.push_back(word);
        exp_wr = (exp_wr + 1) % DEPTH;
    endtask

    task automatic wait_ack(input string name, input int limit);
        int n;
        n = 0;
        while (tx_ack != tx_req && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(tx_ack), 32'(tx_req));
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((dut.count != '0 || rx_req != rx_ack || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(dut.count), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic grant_ack();
        ack_budget = acks_done + 1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tx_req     = 1'b0;
        tx_data    = '0;
        ack_budget = 0;
        cons_auto  = 1'b0;
        exp_q.delete();
        exp_wr = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int n;
        checks     = 0;
        errors     = 0;
        tx_req     = 1'b0;
        tx_data    = '0;
        ack_budget = 0;
        cons_auto  = 1'b0;
        exp_wr     = 0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        #2;
        check("reset_tx_ack", 32'(tx_ack), 32'd0);
        check("reset_rx_req", 32'(rx_req), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_count", 32'(dut.count), 32'd0);
`ifdef LINK_STATUS_EN
        check("reset_status", 32'(status), 32'd0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single word: ack after 1 edge, presented 1 edge later.
        start_push(14'h0ABC);
        tick();
        check("t1_tx_ack_latency", 32'(tx_ack), 32'd1);
        check("t1_rx_req_not_yet", 32'(rx_req), 32'd0);
        tick();
        check("t1_rx_req", 32'(rx_req), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'h0ABC);
        grant_ack();
        wait_idle("t1_drain", 20);

        // Fill and backpressure with a silent consumer.
        for (int v = 1; v <= 4; v++) begin
            start_push(WIDTH'(v));
            wait_ack("t2_push_ack", 10);
        end
        start_push(WIDTH'(5));
        repeat (3) tick();
        check("t2_backpressure", 32'(tx_ack), 32'(!tx_req));
        check("t2_count_full", 32'(dut.count), 32'd4);
        grant_ack();
        n = 0;
        while (dut.count != 3'd3 && n < 10) begin
            tick();
            n++;
        end
        check("t2_count_after_pop", 32'(dut.count), 32'd3);
        check("t2_no_push_at_pop", 32'(tx_ack), 32'(!tx_req));
        tick();
        check("t2_push_after_pop", 32'(tx_ack), 32'(tx_req));
        check("t2_count_refill", 32'(dut.count), 32'd4);
        cons_auto = 1'b1;
        wait_idle("t2_drain", 40);

        // Pointer wrap with an eager consumer.
        for (int i = 0; i < 10; i++) begin
            start_push(WIDTH'(32'h100 + i));
            wait_ack("t3_push_ack", 10);
        end
        wait_idle("t3_drain", 40);
        check("t3_max_count", 32'(max_count), 32'(DEPTH));
        check("t3_wr_ptr", 32'(dut.wr_ptr), 32'(exp_wr));
        check("t3_rd_ptr", 32'(dut.rd_ptr), 32'(exp_wr));

        // Push and pop on the same edge at count 2.
        cons_auto = 1'b0;
        start_push(14'h0201);
        wait_ack("t4_push_a", 10);
        start_push(14'h0202);
        wait_ack("t4_push_b", 10);
        check("t4_count_before", 32'(dut.count), 32'd2);
        check("t4_presenting", 32'(rx_req != rx_ack), 32'd1);
        start_push(14'h0203);
        grant_ack();
        tick();
        check("t4_count_same", 32'(dut.count), 32'd2);
        check("t4_push_taken", 32'(tx_ack), 32'(tx_req));
        cons_auto = 1'b1;
        wait_idle("t4_drain", 40);

        // Asynchronous reset while a word is being presented.
        start_push(14'h0300);
        wait_ack("t5_push_pre", 10);
        wait_idle("t5_pre_drain", 20);
        cons_auto = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            start_push(WIDTH'(32'h300 + i));
            wait_ack("t5_push", 10);
        end
        tick();
        check("t5_count_pre", 32'(dut.count), 32'd3);
        check("t5_tx_ack_pre", 32'(tx_ack), 32'd1);
        check("t5_rx_req_pre", 32'(rx_req), 32'd1);
        #2;
        rst_n      = 1'b0;
        tx_req     = 1'b0;
        tx_data    = '0;
        ack_budget = 0;
        exp_q.delete();
        exp_wr = 0;
        #1;
        check("t5_async_tx_ack", 32'(tx_ack), 32'd0);
        check("t5_async_rx_req", 32'(rx_req), 32'd0);
        check("t5_async_rx_data", 32'(rx_data), 32'd0);
        check("t5_async_count", 32'(dut.count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        cons_auto = 1'b1;
        start_push(14'h0055);
        wait_ack("t5_push_after", 10);
        wait_idle("t5_drain", 20);

`ifdef LINK_STATUS_EN
        // Status: three completed transfers plus one queued word.
        do_reset();
        check("t6_status_reset", 32'(status), 32'd0);
        cons_auto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_push(WIDTH'(32'h400 + i));
            wait_ack("t6_push", 10);
        end
        wait_idle("t6_drain", 40);
        cons_auto = 1'b0;
        start_push(14'h0410);
        wait_ack("t6_push_queued", 10);
        tick();
        check("t6_status", 32'(status), 32'h061);
        cons_auto = 1'b1;
        wait_idle("t6_final_drain", 20);
        do_reset();
        check("t6_status_after_reset", 32'(status), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vfm_core_link.md
VFM_CORE_LINK -- requirements
Module: vfm_core_link

Interface
REQ-001 SHALL have parameter WIDTH, default 14, the data bits per transferred word.
REQ-002 SHALL have parameter DEPTH, default 4, the FIFO entries; a power of two, 2..16.
REQ-003 SHALL have port Clock_pin  input  1  single clock shared with both attached cores.
REQ-004 SHALL have port Resetn_pin  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  WIDTH  producer core's OutN data word.
REQ-006 SHALL have port tx_req  input  1  producer toggle-request, bit 0 of the producer's OutN-1 ack word.
REQ-007 SHALL have port tx_ack  output  1  toggle-acknowledge to the producer's InN-1 (zero-extended by the top level).
REQ-008 SHALL have port rx_data  output  WIDTH  word presented to the consumer core's InN.
REQ-009 SHALL have port rx_req  output  1  toggle-request to the consumer's InN-1.
REQ-010 SHALL have port rx_ack  input  1  consumer toggle-acknowledge, bit 0 of the consumer's OutN-1.
REQ-011 SHALL have port status  output  WIDTH  occupancy and transfer count, present only under LINK_STATUS_EN (see Configuration).

Function
REQ-012 SHALL use toggle handshakes on both sides; a transaction is pending while req != ack.
REQ-013 SHALL push tx_data when tx_req != tx_ack and count < DEPTH, and set tx_ack <= tx_req in the same edge; push-to-ack latency is 1 cycle.
REQ-014 SHALL withhold tx_ack while count == DEPTH, sampling tx_data only on the accepting edge; no word is ever dropped or overwritten.
REQ-015 SHALL evaluate the full condition on count before any same-cycle pop; a push request at full waits one cycle even when a pop completes in that cycle.
REQ-016 SHALL implement the consumer side as a 2-state FSM: IDLE and PRESENT.
REQ-017 In IDLE with count > 0, SHALL load rx_data <= head entry, toggle rx_req, and go to PRESENT; latency from push to rx_req toggle is 1 cycle when the FIFO was empty.
REQ-018 In PRESENT, SHALL hold rx_data stable; when rx_ack == rx_req, SHALL pop the head (rd_ptr+1, count-1) and return to IDLE.
REQ-019 Back-to-back words SHALL therefore be presented at most every 2 cycles after each consumer ack.
REQ-020 SHALL allow a push and a pop in the same cycle with count unchanged.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 count SHALL be log2(DEPTH)+1 bits, never exceed DEPTH, and never underflow.
REQ-023 SHALL deliver words to the consumer in exact push order.

Reset
REQ-024 Resetn_pin low SHALL asynchronously clear tx_ack=0, rx_req=0, rx_data=0, pointers=0, count=0, FSM=IDLE, and status=0, discarding any FIFO contents.
REQ-025 Reset asserted mid-handshake SHALL abandon that transfer; after release, the link behaves as freshly reset (both cores reset from the same Resetn_pin, req=ack=0).

Configuration
REQ-026 Macro LINK_STATUS_EN, when defined, SHALL add port status = {transfer_count[WIDTH-6:0], count[4:0]}.
REQ-027 transfer_count SHALL increment on every pop and wrap to 0 at all-ones.
REQ-028 When LINK_STATUS_EN is undefined, SHALL omit the status port and counter; all other behaviour is identical.

Verification
REQ-029 Single word: after reset, tx_data=14'h0ABC, toggle tx_req 0->1 -> tx_ack=1 next edge; rx_req=1 and rx_data=14'h0ABC one edge later; consumer toggles rx_ack -> count returns to 0.
REQ-030 Fill and backpressure: 5 pushes of 1..5 with the consumer silent, DEPTH=4 -> 5th tx_ack withheld, count=4; one consumer ack -> 5th accepted 1 cycle after the pop; words read out in order 1,2,3,4,5.
REQ-031 Pointer wrap: 10 words 0x100..0x109 streamed with the consumer acking immediately -> all received in order, count never exceeds 4, pointers wrap twice.
REQ-032 Simultaneous events: count=2 with push and pop on the same edge -> count stays 2; at count=4, push with same-cycle pop -> push accepted the following cycle.
REQ-033 Reset mid-operation: count=3 in PRESENT, Resetn_pin pulsed low -> all outputs 0 immediately, asynchronous; a subsequent push of 14'h0055 is delivered normally.
REQ-034 With LINK_STATUS_EN defined: 3 completed transfers and 1 queued word -> status = {transfer_count=3, count=1}; after reset, status = 0.
